async_ring_sequencer: RTL and testbench

Synchronous sequencer that bootstraps, monitors and stops the asynchronous handshake ring of controllers, forks and joins. It injects the start token into the PC-adjust fork with a four-phase request/acknowledge handshake. It then counts circulating tokens and detects a stalled ring with a watchdog. It also drains the ring on request, by gating the token at the fork, before returning to idle.

---
 rtl/async_ring_pkg.sv | 18 +
 rtl/sync2.sv | 19 +
 rtl/async_ring_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_async_ring_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_ring_pkg.sv
// Shared types and default constants for the async ring sequencer.
package async_ring_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INJ_REQ,
    INJ_REL,
    RUN,
    STALL,
    DRAIN
  } ring_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int QUIET_CYCLES_DEF   = 8;
  localparam int CNT_W_DEF          = 32;
  localparam int MAX_REINJECT_DEF   = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level, synchronous active-low reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] pipe;

  // shift the async level through two flops
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pipe <= '0;
    else         pipe <= {pipe[0], d_i};
  end

  assign q_o = pipe[1];

endmodule

// File: rtl/async_ring_sequencer.sv
// Bootstraps, watches and drains the asynchronous handshake ring.
// Optional automatic re-injection after a stall: ASYNC_RING_REINJECT_EN.
module async_ring_sequencer
  import async_ring_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int QUIET_CYCLES   = QUIET_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int MAX_REINJECT   = MAX_REINJECT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             req_loop_i,
  input  logic             ack_inject_i,
  output logic             req_start_o,
  output logic             halt_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] tok_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int QW   = $clog2(QUIET_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_EXP = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [QW-1:0]   QC_MAX = QW'(QUIET_CYCLES);
  localparam logic [QW-1:0]   QC_EXP = QW'(QUIET_CYCLES - 1);

  ring_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [QW-1:0]    qc_q, qc_d;
  logic             stall_q, stall_d;
  logic             pend_q, pend_d;
  logic             restart;
  logic             req_s, ack_s, req_d, tok_edge;

`ifdef ASYNC_RING_REINJECT_EN
  localparam int RW = (MAX_REINJECT > 0) ? $clog2(MAX_REINJECT + 1) : 1;
  logic [RW-1:0] reinj_q, reinj_d;
  logic          fault_q, fault_d;
`endif

  sync2 u_sync_req (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(req_loop_i),   .q_o(req_s));
  sync2 u_sync_ack (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(ack_inject_i), .q_o(ack_s));

  assign tok_edge = req_s & ~req_d;

  // next-state and counter updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    qc_d    = qc_q;
    stall_d = stall_q;
    pend_d  = pend_q;
    restart = 1'b0;
`ifdef ASYNC_RING_REINJECT_EN
    reinj_d = reinj_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: if (start_i) restart = 1'b1;
      INJ_REQ: begin
        if (stop_i) pend_d = 1'b1;
        if (ack_s)  state_d = INJ_REL;
      end
      INJ_REL: begin
        if (stop_i) pend_d = 1'b1;
        if (!ack_s) begin
          // a stop seen during the handshake diverts to DRAIN once it closes
          pend_d = 1'b0;
          if (pend_q || stop_i) begin
            state_d = DRAIN;
            qc_d    = '0;
          end else begin
            state_d = RUN;
            wd_d    = '0;
          end
        end
      end
      RUN: begin
        if (tok_edge) begin
          cnt_d = cnt_q + 1'b1;
          wd_d  = '0;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        // stop beats expiry; a token on the expiry cycle keeps the ring alive
        if (stop_i) begin
          state_d = DRAIN;
          qc_d    = '0;
        end else if (!tok_edge && wd_q >= WD_EXP) begin
          stall_d = 1'b1;
          state_d = STALL;
        end
      end
      STALL: begin
        if (start_i) restart = 1'b1;
        else if (stop_i) state_d = IDLE;
        else if (tok_edge) begin
          cnt_d   = cnt_q + 1'b1;
          wd_d    = '0;
          state_d = RUN;
        end
`ifdef ASYNC_RING_REINJECT_EN
        else if (reinj_q < RW'(MAX_REINJECT)) begin
          reinj_d = reinj_q + 1'b1;
          state_d = INJ_REQ;
        end else begin
          fault_d = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (req_s) qc_d = '0;
        else if (qc_q != QC_MAX) qc_d = qc_q + 1'b1;
        if (!req_s && qc_q >= QC_EXP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = INJ_REQ;
      cnt_d   = '0;
      stall_d = 1'b0;
`ifdef ASYNC_RING_REINJECT_EN
      reinj_d = '0;
      fault_d = 1'b0;
`endif
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      qc_q        <= '0;
      stall_q     <= 1'b0;
      pend_q      <= 1'b0;
      req_d       <= 1'b0;
      req_start_o <= 1'b0;
      halt_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      qc_q        <= qc_d;
      stall_q     <= stall_d;
      pend_q      <= pend_d;
      req_d       <= req_s;
      req_start_o <= (state_d == INJ_REQ);
      halt_o      <= (state_d == DRAIN);
      busy_o      <= (state_d != IDLE);
    end
  end

`ifdef ASYNC_RING_REINJECT_EN
  // re-injection budget and sticky fault
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reinj_q <= '0;
      fault_q <= 1'b0;
    end else begin
      reinj_q <= reinj_d;
      fault_q <= fault_d;
    end
  end
  assign fault_o = fault_q;
`else
  // no re-injection in this build, so a fault can never be raised
  assign fault_o = 1'b0 & (MAX_REINJECT >= 0);
`endif

  assign stall_o   = stall_q;
  assign tok_cnt_o = cnt_q;

endmodule

// File: tb/tb_async_ring_sequencer.sv
// Randomized bench for async_ring_sequencer with a behavioural reference model.
module tb_async_ring_sequencer;

  localparam int T  = 16;
  localparam int Q  = 8;
  localparam int CW = 4;
  localparam int MR = 2;
  localparam int S_IDLE = 0, S_INJ_REQ = 1, S_INJ_REL = 2, S_RUN = 3, S_STALL = 4, S_DRAIN = 5;

  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic ack_inject_i = 1'b0, manual_req = 1'b0, ring_lvl = 1'b0, ring_auto = 1'b0;
  logic req_loop_i;
  logic req_start_o, halt_o, busy_o, stall_o, fault_o;
  logic [CW-1:0] tok_cnt_o;

  int n_chk = 0, n_err = 0;

  // reference model state
  int m_st = S_IDLE, m_cnt = 0, m_idle = 0, m_quiet = 0, m_reinj = 0;
  bit m_stall = 0, m_fault = 0, m_pend = 0;
  bit h1 = 0, h2 = 0, h3 = 0, a1 = 0, a2 = 0;
  bit tok, rs, as, restart;

  assign req_loop_i = ring_auto ? ring_lvl : manual_req;

  initial forever #5 clk = ~clk;

  async_ring_sequencer #(
    .TIMEOUT_CYCLES(T), .QUIET_CYCLES(Q), .CNT_W(CW), .MAX_REINJECT(MR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .req_loop_i(req_loop_i), .ack_inject_i(ack_inject_i),
    .req_start_o(req_start_o), .halt_o(halt_o), .busy_o(busy_o),
    .stall_o(stall_o), .fault_o(fault_o), .tok_cnt_o(tok_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {23'b0, req_start_o, halt_o, busy_o, stall_o, fault_o, tok_cnt_o};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return {23'b0, m_st == S_INJ_REQ, m_st == S_DRAIN, m_st != S_IDLE,
            m_stall, m_fault, CW'(m_cnt)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return req_start_o;
      1: return halt_o;
      default: return fault_o;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic lvl, input int maxc);
    int k = 0;
    while (k < maxc && sel(which) !== lvl) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, sel(which)}, {31'b0, lvl});
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(1); start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
  endtask

  // reference model: synchronizer delay as input history, rules as plain counts
  initial forever begin
    @(posedge clk);
    if (!rst_ni) begin
      m_st = S_IDLE; m_cnt = 0; m_idle = 0; m_quiet = 0; m_reinj = 0;
      m_stall = 0; m_fault = 0; m_pend = 0;
      h1 = 0; h2 = 0; h3 = 0; a1 = 0; a2 = 0;
    end else begin
      tok = h2 && !h3;
      rs = h2;
      as = a2;
      restart = 0;
      case (m_st)
        S_IDLE: if (start_i) restart = 1;
        S_INJ_REQ: begin
          if (stop_i) m_pend = 1;
          if (as) m_st = S_INJ_REL;
        end
        S_INJ_REL: begin
          if (stop_i) m_pend = 1;
          if (!as) begin
            m_st = m_pend ? S_DRAIN : S_RUN;
            m_pend = 0; m_idle = 0; m_quiet = 0;
          end
        end
        S_RUN: begin
          if (tok) begin m_cnt = (m_cnt + 1) % (1 << CW); m_idle = 0; end
          else m_idle++;
          if (stop_i) begin m_st = S_DRAIN; m_quiet = 0; end
          else if (!tok && m_idle >= T) begin m_stall = 1; m_st = S_STALL; end
        end
        S_STALL: begin
          if (start_i) restart = 1;
          else if (stop_i) m_st = S_IDLE;
          else if (tok) begin m_cnt = (m_cnt + 1) % (1 << CW); m_idle = 0; m_st = S_RUN; end
`ifdef ASYNC_RING_REINJECT_EN
          else if (m_reinj < MR) begin m_reinj++; m_st = S_INJ_REQ; end
          else m_fault = 1;
`endif
        end
        S_DRAIN: begin
          if (rs) m_quiet = 0; else m_quiet++;
          if (m_quiet >= Q) m_st = S_IDLE;
        end
        default: ;
      endcase
      if (restart) begin
        m_st = S_INJ_REQ; m_cnt = 0; m_stall = 0; m_fault = 0; m_reinj = 0;
      end
      h3 = h2; h2 = h1; h1 = req_loop_i;
      a2 = a1; a1 = ack_inject_i;
    end
  end

  // every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    chk("cycle", dut_vec(), mdl_vec());
  end

  // fork acknowledge: follows req_start_o five cycles later
  initial begin
    bit d [5];
    d = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        d = '{default: 0};
        ack_inject_i = 1'b0;
      end else begin
        ack_inject_i = d[4];
        for (int i = 4; i > 0; i--) d[i] = d[i-1];
        d[0] = req_start_o;
      end
    end
  end

  // free-running ring activity, used when ring_auto is set
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      if (c == 0) begin
        ring_lvl = ~ring_lvl;
        c = ring_lvl ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 6));
      end else begin
        c--;
      end
    end
  end

  initial begin
    int k;
    tick(3);
    chk("reset_outputs", dut_vec(), 32'h0);
    rst_ni = 1'b1;
    tick(2);

    // start handshake
    pulse_start();
    chk("start_to_req", {31'b0, req_start_o}, 32'd1);
    wait_sig("req_release", 0, 1'b0, 40);
    chk("busy_after_hs", {31'b0, busy_o}, 32'd1);
    tick(9);

    // first token: counter moves on the third edge after the rise
    manual_req = 1'b1; tick(1); manual_req = 1'b0;
    tick(1);
    chk("tok_lat_pre", {28'b0, tok_cnt_o}, 32'd0);
    tick(1);
    chk("tok_lat", {28'b0, tok_cnt_o}, 32'd1);
    tick(3);
    repeat (9) begin manual_req = 1'b1; tick(2); manual_req = 1'b0; tick(3); end
    tick(3);
    chk("tok_cnt_10", {28'b0, tok_cnt_o}, 32'd10);
    repeat (7) begin manual_req = 1'b1; tick(2); manual_req = 1'b0; tick(3); end

    // 18th token wraps the 4-bit counter to 2; watchdog then expires 16 cycles later
    manual_req = 1'b1; tick(1); manual_req = 1'b0;
    tick(2);
    chk("tok_wrap", {28'b0, tok_cnt_o}, 32'd2);
    tick(15);
    chk("stall_pre", {31'b0, stall_o}, 32'd0);
    tick(1);
    chk("stall_at_16", {31'b0, stall_o}, 32'd1);

    // late token: stall stays sticky
    tick(3);
    manual_req = 1'b1; tick(2); manual_req = 1'b0;
    tick(4);
    chk("stall_sticky", {31'b0, stall_o}, 32'd1);
    chk("busy_stall", {31'b0, busy_o}, 32'd1);

    // drain from RUN: IDLE after 8 quiet cycles
    ring_auto = 1'b1; tick(40); ring_auto = 1'b0; manual_req = 1'b0;
    tick(4);
    pulse_stop();
    chk("drain_halt", {31'b0, halt_o}, 32'd1);
    tick(7);
    chk("drain_q7", {31'b0, halt_o}, 32'd1);
    tick(1);
    chk("drain_done", {30'b0, halt_o, busy_o}, 32'd0);

    // stop during INJ_REQ: handshake finishes, then DRAIN
    start_i = 1'b1; tick(1); start_i = 1'b0;
    pulse_stop();
    wait_sig("stopinj_release", 0, 1'b0, 40);
    wait_sig("stopinj_drain", 1, 1'b1, 20);
    chk("stopinj_nostall", {31'b0, stall_o}, 32'd0);
    wait_sig("stopinj_idle", 1, 1'b0, 40);

    // stop on the watchdog expiry cycle: DRAIN wins, no stall
    pulse_start();
    k = 0;
    while (k < 200 && !(m_st == S_RUN && m_idle == T - 1)) begin tick(1); k++; end
    chk("simul_arm", {31'b0, (m_st == S_RUN && m_idle == T - 1)}, 32'd1);
    pulse_stop();
    chk("simul_halt", {31'b0, halt_o}, 32'd1);
    chk("simul_nostall", {31'b0, stall_o}, 32'd0);
    wait_sig("simul_idle", 1, 1'b0, 40);

    // dead ring: re-injection budget then fault, or plain stall
    pulse_start();
`ifdef ASYNC_RING_REINJECT_EN
    wait_sig("fault_set", 2, 1'b1, 600);
`else
    tick(300);
    chk("fault_tied", {31'b0, fault_o}, 32'd0);
`endif
    chk("dead_stall", {31'b0, stall_o}, 32'd1);
    pulse_stop();
    tick(1);
    chk("stall_stop_idle", {31'b0, busy_o}, 32'd0);

    // reset in the middle of INJ_REQ
    pulse_start();
    tick(1);
    chk("rst_mid_pre", {31'b0, req_start_o}, 32'd1);
    rst_ni = 1'b0;
    tick(1);
    chk("rst_mid", dut_vec(), 32'h0);
    rst_ni = 1'b1;
    tick(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start_i = ($urandom_range(0, 39) == 0);
      stop_i  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) ring_auto = ~ring_auto;
      rst_ni  = ($urandom_range(0, 799) != 0);
      tick(1);
    end
    start_i = 1'b0; stop_i = 1'b0; rst_ni = 1'b1; ring_auto = 1'b0;
    tick(5);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
